// File: rtl/fb_rect_writer_if.sv
// Command and frame-buffer write bundle for fb_rect_writer.
// The master side issues rectangle commands and consumes pixel writes. The slave side is the rectangle writer.
interface fb_rect_writer_if #(
  parameter int ADDR_BITS   = 19,
  parameter int COLOR_WIDTH = 12
);
  logic                   cmd_valid;
  logic                   cmd_ready;
  logic [9:0]             cmd_x0;
  logic [8:0]             cmd_y0;
  logic [9:0]             cmd_w;
  logic [8:0]             cmd_h;
  logic [COLOR_WIDTH-1:0] cmd_color;
  logic                   video_on;
  logic                   wr_en;
  logic [ADDR_BITS-1:0]   wr_addr;
  logic [COLOR_WIDTH-1:0] wr_data;
  logic                   busy;
  logic                   done;

  modport master (
    output cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, video_on,
    input  cmd_ready, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_x0, cmd_y0, cmd_w, cmd_h, cmd_color, video_on,
    output cmd_ready, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/fb_rect_writer.sv
// Fills a clipped, single-colour rectangle into the frame buffer at one pixel per clock.
// Optional macro VBLANK_GATE_EN: when it is defined, writes are held off while video_on is high.
module fb_rect_writer #(
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480,
  parameter int ADDR_BITS   = 19,
  parameter int COLOR_WIDTH = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  fb_rect_writer_if.slave   bus
);

  typedef enum logic {IDLE, FILL} state_e;

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [10:0] H_MAX = 11'(H_ACTIVE - 1);
  localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);
  localparam logic [9:0]  V_MAX = 10'(V_ACTIVE - 1);

  state_e                 state_q, state_d;
  logic [9:0]             x_q, x_d, x0_q, x0_d, xEnd_q, xEnd_d;
  logic [8:0]             y_q, y_d, yEnd_q, yEnd_d;
  logic [COLOR_WIDTH-1:0] color_q, color_d, wrData_q, wrData_d;
  logic [ADDR_BITS-1:0]   wrAddr_q, wrAddr_d;
  logic                   wrEn_q, wrEn_d, done_q, done_d, last_q, last_d;

  logic [10:0]            xSum;
  logic [9:0]             ySum;
  logic [9:0]             cmdXEnd;
  logic [8:0]             cmdYEnd;
  logic                   cmdDegenerate;
  logic                   gateOpen;

  logic [9:0]             curX, rowStart, endX;
  logic [8:0]             curY, endY;
  logic [COLOR_WIDTH-1:0] curColor;
  logic                   walk;

  // End coordinates are formed one bit wider than the coordinate so large widths cannot wrap.
  always_comb begin
    xSum          = {1'b0, bus.cmd_x0} + {1'b0, bus.cmd_w} - 11'd1;
    ySum          = {1'b0, bus.cmd_y0} + {1'b0, bus.cmd_h} - 10'd1;
    cmdXEnd       = (xSum > H_MAX) ? H_MAX[9:0] : xSum[9:0];
    cmdYEnd       = (ySum > V_MAX) ? V_MAX[8:0] : ySum[8:0];
    cmdDegenerate = (bus.cmd_w == 10'd0) || (bus.cmd_h == 9'd0) ||
                    ({1'b0, bus.cmd_x0} >= H_LIM) || ({1'b0, bus.cmd_y0} >= V_LIM);
`ifdef VBLANK_GATE_EN
    gateOpen      = !bus.video_on;
`else
    gateOpen      = 1'b1;
`endif
  end

  // The walker position is the next pixel to write. Accepting a command feeds it directly from the command inputs, so the first write needs no extra cycle.
  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    x0_d     = x0_q;
    xEnd_d   = xEnd_q;
    yEnd_d   = yEnd_q;
    color_d  = color_q;
    wrEn_d   = 1'b0;
    wrAddr_d = wrAddr_q;
    wrData_d = wrData_q;
    done_d   = 1'b0;
    last_d   = last_q;
    curX     = x_q;
    curY     = y_q;
    rowStart = x0_q;
    endX     = xEnd_q;
    endY     = yEnd_q;
    curColor = color_q;
    walk     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (cmdDegenerate) begin
            done_d = 1'b1;
          end else begin
            state_d  = FILL;
            x0_d     = bus.cmd_x0;
            xEnd_d   = cmdXEnd;
            yEnd_d   = cmdYEnd;
            color_d  = bus.cmd_color;
            last_d   = 1'b0;
            curX     = bus.cmd_x0;
            curY     = bus.cmd_y0;
            rowStart = bus.cmd_x0;
            endX     = cmdXEnd;
            endY     = cmdYEnd;
            curColor = bus.cmd_color;
            walk     = 1'b1;
          end
        end
      end
      FILL: begin
        if (last_q) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          walk = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (walk) begin
      x_d = curX;
      y_d = curY;
      if (gateOpen) begin
        wrEn_d   = 1'b1;
        wrAddr_d = ADDR_BITS'({curY, curX});
        wrData_d = curColor;
        if (curX == endX) begin
          if (curY == endY) begin
            last_d = 1'b1;
          end else begin
            x_d = rowStart;
            y_d = curY + 9'd1;
          end
        end else begin
          x_d = curX + 10'd1;
        end
      end
    end
  end

  // Reset abandons any fill in progress and clears every visible output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      x0_q     <= '0;
      xEnd_q   <= '0;
      yEnd_q   <= '0;
      color_q  <= '0;
      wrEn_q   <= 1'b0;
      wrAddr_q <= '0;
      wrData_q <= '0;
      done_q   <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      x0_q     <= x0_d;
      xEnd_q   <= xEnd_d;
      yEnd_q   <= yEnd_d;
      color_q  <= color_d;
      wrEn_q   <= wrEn_d;
      wrAddr_q <= wrAddr_d;
      wrData_q <= wrData_d;
      done_q   <= done_d;
      last_q   <= last_d;
    end
  end

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.busy      = (state_q == FILL);
  assign bus.wr_en     = wrEn_q;
  assign bus.wr_addr   = wrAddr_q;
  assign bus.wr_data   = wrData_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed bench for fb_rect_writer: a reference model queues the expected writes, and every DUT write is popped from that queue and compared.
module tb_fb_rect_writer;

  typedef struct packed {
    logic [18:0] addr;
    logic [11:0] data;
  } wrItem_t;

  logic clk;
  logic rst_n;

  fb_rect_writer_if #(.ADDR_BITS(19), .COLOR_WIDTH(12)) bus ();

  fb_rect_writer #(
    .H_ACTIVE(640), .V_ACTIVE(480), .ADDR_BITS(19), .COLOR_WIDTH(12)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wrItem_t expQ[$];
  int assertCount = 0;
  int failCount   = 0;
  int cyc = 0;
  int writesSeen = 0;
  int firstWriteCyc = -1;
  int lastWriteCyc = -1;
  int doneSeen = 0;
  int doneCyc = -1;
  int acceptCyc = -1;

  // Each comparison runs as an immediate assertion, and every failure is counted.
  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assertCount++;
    assert (obs === exp)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model. It clips the rectangle to the 640x480 screen and queues the writes in row-major order.
  task automatic pushExpected(input int x0, input int y0, input int w, input int h,
                              input logic [11:0] c);
    int xe;
    int ye;
    wrItem_t item;
    if (w == 0 || h == 0 || x0 >= 640 || y0 >= 480) return;
    xe = x0 + w - 1;
    if (xe > 639) xe = 639;
    ye = y0 + h - 1;
    if (ye > 479) ye = 479;
    for (int y = y0; y <= ye; y++) begin
      for (int x = x0; x <= xe; x++) begin
        item.addr = 19'(y * 1024 + x);
        item.data = c;
        expQ.push_back(item);
      end
    end
  endtask

  task automatic checkOutput();
    wrItem_t e;
    if (bus.wr_en === 1'b1) begin
      if (expQ.size() == 0) begin
        checkVal("unexpected write", 32'(bus.wr_addr), 32'hFFFF_FFFF);
      end else begin
        e = expQ.pop_front();
        checkVal("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
        checkVal("wr_data", 32'(bus.wr_data), 32'(e.data));
      end
      writesSeen++;
      if (firstWriteCyc < 0) firstWriteCyc = cyc;
      lastWriteCyc = cyc;
    end
    if (bus.done === 1'b1) begin
      doneSeen++;
      doneCyc = cyc;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    checkOutput();
  endtask

  // Present a command for one edge, then scramble the command fields to confirm they were latched.
  task automatic applyStimulus(input int x0, input int y0, input int w, input int h,
                               input logic [11:0] c);
    writesSeen    = 0;
    firstWriteCyc = -1;
    lastWriteCyc  = -1;
    bus.cmd_valid = 1'b1;
    bus.cmd_x0    = 10'(x0);
    bus.cmd_y0    = 9'(y0);
    bus.cmd_w     = 10'(w);
    bus.cmd_h     = 9'(h);
    bus.cmd_color = c;
    pushExpected(x0, y0, w, h, c);
    tick();
    acceptCyc     = cyc;
    bus.cmd_valid = 1'b0;
    bus.cmd_x0    = 10'($urandom);
    bus.cmd_y0    = 9'($urandom);
    bus.cmd_w     = 10'($urandom);
    bus.cmd_h     = 9'($urandom);
    bus.cmd_color = 12'($urandom);
  endtask

  task automatic waitDone(input string tag, input int budget);
    int n = 0;
    int startDone = doneSeen;
    while (doneSeen == startDone && n < budget) begin
      tick();
      n++;
    end
    checkVal({tag, " done seen"}, 32'(doneSeen - startDone), 32'd1);
  endtask

  int startDone;
  int doneCycB;
  int n;

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_x0    = '0;
    bus.cmd_y0    = '0;
    bus.cmd_w     = '0;
    bus.cmd_h     = '0;
    bus.cmd_color = '0;
    bus.video_on  = 1'b0;

    #2;
    checkVal("reset wr_en", 32'(bus.wr_en), 32'd0);
    checkVal("reset wr_addr", 32'(bus.wr_addr), 32'd0);
    checkVal("reset wr_data", 32'(bus.wr_data), 32'd0);
    checkVal("reset busy", 32'(bus.busy), 32'd0);
    checkVal("reset done", 32'(bus.done), 32'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    checkVal("idle cmd_ready", 32'(bus.cmd_ready), 32'd1);

    // Basic 3x2 fill.
    startDone = doneSeen;
    applyStimulus(10, 20, 3, 2, 12'hF00);
    checkVal("A first write latency", 32'(firstWriteCyc), 32'(acceptCyc));
    checkVal("A busy", 32'(bus.busy), 32'd1);
    checkVal("A cmd_ready low", 32'(bus.cmd_ready), 32'd0);
    waitDone("A", 20);
    checkVal("A ready at done", 32'(bus.cmd_ready), 32'd1);
    checkVal("A busy at done", 32'(bus.busy), 32'd0);
    checkVal("A write count", 32'(writesSeen), 32'd6);
    checkVal("A consecutive", 32'(lastWriteCyc - firstWriteCyc + 1), 32'd6);
    checkVal("A done after last", 32'(doneCyc), 32'(lastWriteCyc + 1));
    tick();
    checkVal("A done one cycle", 32'(bus.done), 32'd0);
    checkVal("A queue drained", 32'(expQ.size()), 32'd0);

    // Bottom-right clipping.
    applyStimulus(638, 479, 5, 4, 12'h0AB);
    waitDone("clip", 20);
    checkVal("clip write count", 32'(writesSeen), 32'd2);
    checkVal("clip queue drained", 32'(expQ.size()), 32'd0);
    tick();

    // Degenerate commands: zero width, then x0 off the screen.
    startDone = doneSeen;
    applyStimulus(5, 5, 0, 3, 12'h111);
    checkVal("w0 done next cycle", 32'(doneCyc), 32'(acceptCyc));
    checkVal("w0 cmd_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (3) tick();
    checkVal("w0 done pulses", 32'(doneSeen - startDone), 32'd1);
    checkVal("w0 no writes", 32'(writesSeen), 32'd0);
    startDone = doneSeen;
    applyStimulus(640, 5, 4, 3, 12'h222);
    checkVal("x640 done next cycle", 32'(doneCyc), 32'(acceptCyc));
    checkVal("x640 cmd_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (3) tick();
    checkVal("x640 done pulses", 32'(doneSeen - startDone), 32'd1);
    checkVal("x640 no writes", 32'(writesSeen), 32'd0);

    // Back-to-back: the second command is held pending until the done cycle of the first.
    applyStimulus(0, 0, 4, 1, 12'h0F0);
    bus.cmd_valid = 1'b1;
    bus.cmd_x0    = 10'd5;
    bus.cmd_y0    = 9'd5;
    bus.cmd_w     = 10'd2;
    bus.cmd_h     = 9'd2;
    bus.cmd_color = 12'h00F;
    pushExpected(5, 5, 2, 2, 12'h00F);
    startDone = doneSeen;
    n = 0;
    while (doneSeen == startDone && n < 50) begin
      tick();
      n++;
    end
    checkVal("b2b B done seen", 32'(doneSeen - startDone), 32'd1);
    checkVal("b2b ready at done", 32'(bus.cmd_ready), 32'd1);
    checkVal("b2b B write count", 32'(writesSeen), 32'd4);
    doneCycB      = cyc;
    writesSeen    = 0;
    firstWriteCyc = -1;
    tick();
    bus.cmd_valid = 1'b0;
    checkVal("b2b C first write", 32'(firstWriteCyc), 32'(doneCycB + 1));
    waitDone("b2b C", 20);
    checkVal("b2b C write count", 32'(writesSeen), 32'd4);
    checkVal("b2b queue drained", 32'(expQ.size()), 32'd0);
    tick();

    // Asynchronous reset in the middle of a large fill.
    applyStimulus(0, 0, 100, 100, 12'h555);
    repeat (50) tick();
    #3;
    rst_n = 1'b0;
    #1;
    checkVal("midreset wr_en", 32'(bus.wr_en), 32'd0);
    checkVal("midreset busy", 32'(bus.busy), 32'd0);
    checkVal("midreset done", 32'(bus.done), 32'd0);
    checkVal("midreset wr_addr", 32'(bus.wr_addr), 32'd0);
    expQ.delete();
    repeat (2) tick();
    rst_n      = 1'b1;
    writesSeen = 0;
    startDone  = doneSeen;
    repeat (10) tick();
    checkVal("postreset cmd_ready", 32'(bus.cmd_ready), 32'd1);
    checkVal("postreset no writes", 32'(writesSeen), 32'd0);
    checkVal("postreset no done", 32'(doneSeen - startDone), 32'd0);

    // Raise video_on for three edges in the middle of a fill.
    applyStimulus(100, 200, 4, 3, 12'hABC);
    repeat (3) tick();
    bus.video_on = 1'b1;
    repeat (3) tick();
    bus.video_on = 1'b0;
    waitDone("video", 40);
    checkVal("video write count", 32'(writesSeen), 32'd12);
    checkVal("video queue drained", 32'(expQ.size()), 32'd0);
`ifdef VBLANK_GATE_EN
    checkVal("video gated span", 32'(lastWriteCyc - firstWriteCyc + 1), 32'd15);
`else
    checkVal("video ungated span", 32'(lastWriteCyc - firstWriteCyc + 1), 32'd12);
`endif
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
